// File: rtl/access_arbiter_pkg.sv
// Shared definitions for the access arbiter.
//   DefNReq / DefTimeout : default requester count and ISSUE timeout in cycles
//   TimerW               : width of the ISSUE wait timer
//   state_e              : arbiter FSM state encoding
package access_arbiter_pkg;

    localparam int unsigned DefNReq    = 4;
    localparam int unsigned DefTimeout = 15;
    localparam int unsigned TimerW     = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StRelease = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index for this pick
//   valid : at least one request is present
//   index : first requesting index found walking the ring upward from ptr
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IdxW  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IdxW-1:0]  ptr,
    output logic             valid,
    output logic [IdxW-1:0]  index
);

    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    logic            found;

    always_comb begin
        cand     = 0;
        cand_idx = '0;
        found    = 1'b0;
        index    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = cand[IdxW-1:0];
            // Lowest ring offset from ptr wins.
            if (!found && req[cand_idx]) begin
                index = cand_idx;
                found = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/access_arbiter.sv
// Round-robin arbiter granting one requester at a time access to a shared access FSM.
//   clk, rst_n           : clock (rising edge) and asynchronous active-low reset
//   req, req_op          : per-requester level request and op (0=read, 1=write)
//   gnt                  : registered one-hot grant, held IDLE->ISSUE->RELEASE
//   done, err            : one-cycle completion / error pulses (never together)
//   busy                 : high whenever the FSM is not idle
//   acc_select, acc_op   : registered command to the access FSM
//   acc_valid, acc_rw    : status from the access FSM
module access_arbiter
    import access_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = DefNReq,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_op,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] done,
    output logic             err,
    output logic             busy,
    output logic             acc_select,
    output logic             acc_op,
    input  logic             acc_valid,
    input  logic             acc_rw
);

    localparam int unsigned     IdxW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(N_REQ - 1);
    localparam logic [TimerW-1:0] TimeoutVal = TimerW'(TIMEOUT);

    state_e state_q, state_d;

    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              op_q, op_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              sel_q, sel_d;
    logic              acc_op_q, acc_op_d;

    logic              pick_valid;
    logic [IdxW-1:0]   pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IdxW  (IdxW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // acc_valid in the timeout cycle is still treated as a response.
                if (acc_valid || (timer_q == TimeoutVal)) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!acc_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the datapath and registered outputs.
    always_comb begin
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        timer_d = timer_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    idx_d           = pick_idx;
                    op_d            = req_op[pick_idx];
                    timer_d         = '0;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                end
            end
            StIssue: begin
                if (acc_valid) begin
                    if (acc_rw == op_q) begin
                        done_d = gnt_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (timer_q == TimeoutVal) begin
                    err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StRelease: begin
                if (!acc_valid) begin
                    gnt_d = '0;
                    ptr_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                gnt_d = '0;
            end
        endcase
        busy_d   = (state_d != StIdle);
        sel_d    = (state_d == StIssue);
        // acc_op is forced low whenever select is low.
        acc_op_d = (state_d == StIssue) && op_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            idx_q    <= '0;
            op_q     <= 1'b0;
            timer_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            sel_q    <= 1'b0;
            acc_op_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            timer_q  <= timer_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            sel_q    <= sel_d;
            acc_op_q <= acc_op_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign acc_select = sel_q;
    assign acc_op     = acc_op_q;

endmodule

// File: tb/tb_access_arbiter.sv
// Directed self-checking bench for access_arbiter (N_REQ=4, TIMEOUT=15).
module tb_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] req_op;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       err;
    logic       busy;
    logic       acc_select;
    logic       acc_op;
    logic       acc_valid;
    logic       acc_rw;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_order [5];

    always #5 clk = ~clk;

    access_arbiter #(
        .N_REQ   (4),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_op     (req_op),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .acc_select (acc_select),
        .acc_op     (acc_op),
        .acc_valid  (acc_valid),
        .acc_rw     (acc_rw)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; req_op = '0; acc_valid = 1'b0; acc_rw = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req = '0; req_op = '0; acc_valid = 1'b0; acc_rw = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, err, busy, acc_select, acc_op} !== 12'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b",
                     {gnt, done, err, busy, acc_select, acc_op}, 12'b0);
        end
        req = 4'b1111;
        tick();
        checks++;
        if ({gnt, busy, acc_select} !== 6'b0) begin
            failures++;
            $display("FAIL reset_holds got=%b exp=%b", {gnt, busy, acc_select}, 6'b0);
        end
        req = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        req = 4'b0001; req_op = 4'b0000;
        tick();
        checks++;
        if ({gnt, acc_select, acc_op, busy} !== 7'b0001_1_0_1) begin
            failures++;
            $display("FAIL read_grant got=%b exp=%b", {gnt, acc_select, acc_op, busy}, 7'b0001_1_0_1);
        end
        req = '0;
        tick();
        tick();
        checks++;
        if ({done, err, acc_select} !== 6'b0000_0_1) begin
            failures++;
            $display("FAIL read_wait got=%b exp=%b", {done, err, acc_select}, 6'b0000_0_1);
        end
        acc_valid = 1'b1; acc_rw = 1'b0;
        tick();
        checks++;
        if ({done, err, acc_select, gnt} !== 10'b0001_0_0_0001) begin
            failures++;
            $display("FAIL read_done got=%b exp=%b", {done, err, acc_select, gnt}, 10'b0001_0_0_0001);
        end
        acc_valid = 1'b0;
        tick();
        checks++;
        if ({done, gnt, busy} !== 9'b0) begin
            failures++;
            $display("FAIL read_idle got=%b exp=%b", {done, gnt, busy}, 9'b0);
        end
    endtask

    // ptr should now be 1, so port 1 beats port 0.
    task automatic test_ptr_advance();
        req = 4'b0011; req_op = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL ptr_advance got=%b exp=%b", gnt, 4'b0010);
        end
        acc_valid = 1'b1; acc_rw = 1'b0;
        tick();
        checks++;
        if (done !== 4'b0010) begin
            failures++;
            $display("FAIL ptr_done got=%b exp=%b", done, 4'b0010);
        end
        acc_valid = 1'b0; req = '0;
        tick();
    endtask

    task automatic test_fairness();
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111; req_op = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({gnt, done} !== {exp_order[i], 4'b0000}) begin
                failures++;
                $display("FAIL fair_grant[%0d] got=%b exp=%b", i, {gnt, done}, {exp_order[i], 4'b0000});
            end
            acc_valid = 1'b1; acc_rw = 1'b0;
            tick();
            checks++;
            if (done !== exp_order[i]) begin
                failures++;
                $display("FAIL fair_done[%0d] got=%b exp=%b", i, done, exp_order[i]);
            end
            acc_valid = 1'b0;
            tick();
        end
        req = '0;
    endtask

    // ptr=1 after fairness; port 1 is granted and the access FSM never answers.
    task automatic test_timeout();
        req = 4'b0010; req_op = 4'b0000; acc_valid = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL timeout_grant got=%b exp=%b", gnt, 4'b0010);
        end
        req = '0;
        repeat (15) tick();
        checks++;
        if ({acc_select, err} !== 2'b10) begin
            failures++;
            $display("FAIL timeout_early got=%b exp=%b", {acc_select, err}, 2'b10);
        end
        tick();
        checks++;
        if ({err, done, acc_select, busy} !== 7'b1_0000_0_1) begin
            failures++;
            $display("FAIL timeout_err got=%b exp=%b", {err, done, acc_select, busy}, 7'b1_0000_0_1);
        end
        tick();
        checks++;
        if ({err, busy, gnt} !== 6'b0) begin
            failures++;
            $display("FAIL timeout_idle got=%b exp=%b", {err, busy, gnt}, 6'b0);
        end
    endtask

    // ptr=2; write requested, read reported; req/req_op changes must not matter.
    task automatic test_mismatch();
        req = 4'b0100; req_op = 4'b0100;
        tick();
        checks++;
        if ({gnt, acc_op} !== 5'b0100_1) begin
            failures++;
            $display("FAIL mismatch_grant got=%b exp=%b", {gnt, acc_op}, 5'b0100_1);
        end
        req = '0; req_op = '0; acc_valid = 1'b1; acc_rw = 1'b0;
        tick();
        checks++;
        if ({err, done, acc_select, acc_op} !== 7'b1_0000_0_0) begin
            failures++;
            $display("FAIL mismatch_err got=%b exp=%b", {err, done, acc_select, acc_op}, 7'b1_0000_0_0);
        end
        acc_valid = 1'b0;
        tick();
        checks++;
        if ({busy, err} !== 2'b00) begin
            failures++;
            $display("FAIL mismatch_idle got=%b exp=%b", {busy, err}, 2'b00);
        end
    endtask

    // ptr=3 before reset; after reset req=1100 must pick port 2, proving ptr=0.
    task automatic test_reset_mid_issue();
        req = 4'b0100; req_op = 4'b0000;
        tick();
        tick();
        checks++;
        if ({gnt, acc_select} !== 5'b0100_1) begin
            failures++;
            $display("FAIL rst_mid_pre got=%b exp=%b", {gnt, acc_select}, 5'b0100_1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, done, err, busy, acc_select, acc_op} !== 12'b0) begin
            failures++;
            $display("FAIL rst_mid_async got=%b exp=%b",
                     {gnt, done, err, busy, acc_select, acc_op}, 12'b0);
        end
        tick();
        checks++;
        if ({done, err} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid_nopulse got=%b exp=%b", {done, err}, 5'b0);
        end
        req = 4'b1100;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({gnt, acc_select} !== 5'b0100_1) begin
            failures++;
            $display("FAIL rst_mid_regrant got=%b exp=%b", {gnt, acc_select}, 5'b0100_1);
        end
        acc_valid = 1'b1; acc_rw = 1'b0;
        tick();
        checks++;
        if (done !== 4'b0100) begin
            failures++;
            $display("FAIL rst_mid_done got=%b exp=%b", done, 4'b0100);
        end
        acc_valid = 1'b0; req = '0;
        tick();
    endtask

    // ptr=3; write completes, then acc_valid lingers high in RELEASE.
    task automatic test_release_hold();
        req = 4'b1000; req_op = 4'b1000;
        tick();
        checks++;
        if ({gnt, acc_op} !== 5'b1000_1) begin
            failures++;
            $display("FAIL hold_grant got=%b exp=%b", {gnt, acc_op}, 5'b1000_1);
        end
        req = '0; req_op = '0; acc_valid = 1'b1; acc_rw = 1'b1;
        tick();
        checks++;
        if ({done, err} !== 5'b1000_0) begin
            failures++;
            $display("FAIL hold_done got=%b exp=%b", {done, err}, 5'b1000_0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({acc_select, acc_op, busy, gnt, done} !== 11'b0_0_1_1000_0000) begin
                failures++;
                $display("FAIL hold_cycle[%0d] got=%b exp=%b", i,
                         {acc_select, acc_op, busy, gnt, done}, 11'b0_0_1_1000_0000);
            end
        end
        acc_valid = 1'b0;
        tick();
        checks++;
        if ({gnt, busy} !== 5'b0) begin
            failures++;
            $display("FAIL hold_release got=%b exp=%b", {gnt, busy}, 5'b0);
        end
    endtask

    // ptr=0; two held requests, fastest possible handshake gives grants 3 edges apart.
    task automatic test_back_to_back();
        req = 4'b0011; req_op = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL b2b_first got=%b exp=%b", gnt, 4'b0001);
        end
        acc_valid = 1'b1; acc_rw = 1'b0;
        tick();
        acc_valid = 1'b0;
        tick();
        checks++;
        if ({gnt, busy} !== 5'b0) begin
            failures++;
            $display("FAIL b2b_gap got=%b exp=%b", {gnt, busy}, 5'b0);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL b2b_second got=%b exp=%b", gnt, 4'b0010);
        end
        acc_valid = 1'b1;
        tick();
        checks++;
        if ({done, err} !== 5'b0010_0) begin
            failures++;
            $display("FAIL b2b_done got=%b exp=%b", {done, err}, 5'b0010_0);
        end
        acc_valid = 1'b0; req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_ptr_advance();
        test_fairness();
        test_timeout();
        test_mismatch();
        test_reset_mid_issue();
        test_release_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/access_arbiter.md
ACCESS_ARBITER -- requirements
Module: access_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles in ISSUE waiting for acc_valid (1..255).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req  input  N_REQ  per-requester access request, level.
REQ-006 SHALL have port req_op  input  N_REQ  per-requester operation, 0=read, 1=write.
REQ-007 SHALL have port gnt  output  N_REQ  one-hot grant, registered.
REQ-008 SHALL have port done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port err  output  1  one-cycle pulse on timeout or rw mismatch.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port acc_select  output  1  select to the access FSM.
REQ-012 SHALL have port acc_op  output  1  op to the access FSM, 0=read, 1=write.
REQ-013 SHALL have port acc_valid  input  1  access FSM valid (state bit 1).
REQ-014 SHALL have port acc_rw  input  1  access FSM rw (state bit 0).

Function
REQ-015 SHALL implement states IDLE, ISSUE, RELEASE.
REQ-016 IDLE: if any req bit is high, SHALL pick the winner round-robin starting at pointer ptr, latch index and req_op[index], set gnt one-hot, and enter ISSUE next cycle; otherwise stay.
REQ-017 Latency: req sampled high in IDLE at edge k SHALL give gnt, acc_select=1, acc_op valid after edge k+1.
REQ-018 ISSUE: SHALL hold acc_select=1 and acc_op=latched op; SHALL increment an 8-bit timer each cycle from 0.
REQ-019 ISSUE with acc_valid=1 and acc_rw==latched op SHALL pulse done[index] for one cycle and enter RELEASE.
REQ-020 ISSUE with acc_valid=1 and acc_rw!=latched op SHALL pulse err, not pulse done, and enter RELEASE.
REQ-021 ISSUE with timer==TIMEOUT and acc_valid=0 SHALL pulse err and enter RELEASE; acc_valid=1 in that same cycle takes priority (REQ-019/020).
REQ-022 RELEASE: SHALL drive acc_select=0, keep gnt; on acc_valid=0 SHALL clear gnt, set ptr=(index+1) mod N_REQ, and enter IDLE.
REQ-023 No re-arbitration SHALL occur before IDLE; minimum spacing between grants is 3 cycles.
REQ-024 Dropping req[index] or changing req_op during ISSUE/RELEASE SHALL NOT abort or alter the transaction.
REQ-025 Simultaneous requests SHALL be served in ring order from ptr; a continuously requesting port SHALL wait at most N_REQ-1 transactions.
REQ-026 acc_op SHALL be 0 when acc_select=0; done and err SHALL never be high together.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, ptr=0, timer=0, gnt=0, done=0, err=0, busy=0, acc_select=0, acc_op=0.
REQ-028 Reset mid-transaction SHALL abandon it without a done or err pulse; first grant after release SHALL follow REQ-017.

Structure
REQ-029 State encoding and default values of N_REQ/TIMEOUT SHALL live in shared package access_arbiter_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs req, ptr; outputs valid, index), purely combinational.
REQ-031 All outputs except done pulses derived in same cycle SHALL be registered; no combinational path from acc_valid to acc_select.

Verification
REQ-032 Single read: req=0001, req_op=0, acc_valid rises 2 cycles after acc_select -> gnt=0001, acc_op=0, done=0001 one cycle, ptr=1.
REQ-033 Fairness: req=1111 held, model returns valid after 1 cycle -> grant order 0001,0010,0100,1000,0001; no done on ungranted ports.
REQ-034 Timeout: TIMEOUT=15, acc_valid held 0 -> err pulse after timer reaches 15, no done, return to IDLE.
REQ-035 Mismatch: req_op=1, model returns acc_rw=0 with acc_valid=1 -> err pulse, done stays 0.
REQ-036 Reset mid-ISSUE: rst_n low 1 cycle with gnt=0100 -> all outputs 0 at once, next req=0100 granted after one edge, ptr restarts at 0.
REQ-037 RELEASE hold: acc_valid stays 1 for 5 cycles after done -> acc_select=0, busy=1, gnt held until acc_valid=0.
